// File: rtl/bnn_pkg.sv
// Shared definitions for the psum binarizer: default widths, activation word
// format, control FSM states and a signed saturating adder.
package bnn_pkg;

  localparam int BNN_WIDTH     = 14;
  localparam int BNN_ACC_WIDTH = 18;
  localparam int PACK          = 27;
  localparam int CNT_W         = 5;

  typedef enum logic {
    ST_RUN        = 1'b0,
    ST_FLUSH_WAIT = 1'b1
  } ctrl_state_t;

  // Adds two sign-extended operands and clamps the result to a signed w-bit range.
  // Operands must already be sign-extended to 64 bits.
  function automatic logic signed [63:0] sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int unsigned        w
  );
    logic signed [64:0] s;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    s  = {a[63], a} + {b[63], b};
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (w - 1));
    if (s > hi) begin
      sat_add = $signed(hi[63:0]);
    end else if (s < lo) begin
      sat_add = $signed(lo[63:0]);
    end else begin
      sat_add = $signed(s[63:0]);
    end
  endfunction

endpackage

// File: rtl/psum_accumulator.sv
// Sums PASSES psums per output neuron with saturation and binarizes the total
// against the threshold on the final pass.
module psum_accumulator
  import bnn_pkg::*;
#(
  parameter int WIDTH     = BNN_WIDTH,
  parameter int ACC_WIDTH = BNN_ACC_WIDTH,
  parameter int PASSES    = 4
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        clear,
  input  logic                        psum_fire,
  input  logic signed [WIDTH-1:0]     psum,
  input  logic signed [ACC_WIDTH-1:0] threshold,
  output logic                        neuron_done,
  output logic                        act_bit,
  output logic                        busy
);

  localparam int PC_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [PC_W-1:0] LAST_PASS = PC_W'(PASSES - 1);

  logic signed [ACC_WIDTH-1:0] acc_reg;
  logic        [PC_W-1:0]      pass_cnt_reg;
  logic signed [63:0]          acc_wide;
  logic signed [63:0]          psum_wide;
  logic signed [63:0]          thr_wide;
  logic signed [63:0]          sum_wide;
  logic                        last_pass;

  assign acc_wide  = {{(64 - ACC_WIDTH){acc_reg[ACC_WIDTH-1]}}, acc_reg};
  assign psum_wide = {{(64 - WIDTH){psum[WIDTH-1]}}, psum};
  assign thr_wide  = {{(64 - ACC_WIDTH){threshold[ACC_WIDTH-1]}}, threshold};
  assign sum_wide  = sat_add(acc_wide, psum_wide, ACC_WIDTH);

  assign last_pass   = (pass_cnt_reg == LAST_PASS);
  assign neuron_done = psum_fire & last_pass;
  // Saturated sum always fits ACC_WIDTH, so the wide compare equals the narrow one.
  assign act_bit     = (sum_wide >= thr_wide);
  assign busy        = (pass_cnt_reg != '0);

  always_ff @(posedge clk_in) begin
    if (rst_in || clear) begin
      acc_reg      <= '0;
      pass_cnt_reg <= '0;
    end else if (psum_fire) begin
      if (last_pass) begin
        acc_reg      <= '0;
        pass_cnt_reg <= '0;
      end else begin
        acc_reg      <= sum_wide[ACC_WIDTH-1:0];
        pass_cnt_reg <= pass_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/psum_binarizer.sv
// Binarizes accumulated PE-row psums and packs 27 activations per output word,
// with a sticky flush that emits partially filled words.
module psum_binarizer
  import bnn_pkg::*;
#(
  parameter int WIDTH     = BNN_WIDTH,
  parameter int ACC_WIDTH = BNN_ACC_WIDTH,
  parameter int PASSES    = 4
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic signed [ACC_WIDTH-1:0] cfg_threshold_in,
  input  logic                        psum_valid_in,
  output logic                        psum_ready_out,
  input  logic signed [WIDTH-1:0]     psum_in,
  input  logic                        flush_in,
  output logic                        act_valid_out,
  input  logic                        act_ready_in,
  output logic [PACK-1:0]             act_out,
  output logic [CNT_W-1:0]            act_count_out,
  output logic                        busy_out
);

  ctrl_state_t state_reg;
  ctrl_state_t state_next;

  logic             out_free;
  logic             psum_fire;
  logic             flush_exec;
  logic             neuron_done;
  logic             new_bit;
  logic             acc_busy;
  logic             word_full;
  logic [PACK-1:0]  pack_reg;
  logic [PACK-1:0]  pack_with_bit;
  logic [CNT_W-1:0] bit_cnt_reg;

  // The output register is free when empty or being drained this cycle.
  assign out_free       = ~act_valid_out | act_ready_in;
  assign psum_ready_out = ~rst_in & out_free;
  assign psum_fire      = psum_valid_in & psum_ready_out;

  psum_accumulator #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .PASSES    (PASSES)
  ) u_acc (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .clear       (flush_exec),
    .psum_fire   (psum_fire),
    .psum        (psum_in),
    .threshold   (cfg_threshold_in),
    .neuron_done (neuron_done),
    .act_bit     (new_bit),
    .busy        (acc_busy)
  );

  // First neuron lands in the MSB; slot gi receives the neuron at index PACK-1-gi.
  generate
    for (genvar gi = 0; gi < PACK; gi++) begin : g_pack
      assign pack_with_bit[gi] = pack_reg[gi] |
                                 (new_bit & (bit_cnt_reg == CNT_W'(PACK - 1 - gi)));
    end
  endgenerate

  assign word_full = neuron_done & (bit_cnt_reg == CNT_W'(PACK - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    flush_exec = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (flush_in) begin
          state_next = ST_FLUSH_WAIT;
        end
      end
      ST_FLUSH_WAIT: begin
        // A psum accepted this cycle is never split; flush waits for a quiet cycle.
        if (!psum_fire && out_free) begin
          flush_exec = 1'b1;
          state_next = ST_RUN;
        end
        if (flush_in) begin
          state_next = ST_FLUSH_WAIT;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pack_reg      <= '0;
      bit_cnt_reg   <= '0;
      act_valid_out <= 1'b0;
      act_out       <= '0;
      act_count_out <= '0;
    end else begin
      if (act_valid_out && act_ready_in) begin
        act_valid_out <= 1'b0;
      end
      if (word_full) begin
        act_out       <= pack_with_bit;
        act_count_out <= CNT_W'(PACK);
        act_valid_out <= 1'b1;
        pack_reg      <= '0;
        bit_cnt_reg   <= '0;
      end else if (neuron_done) begin
        pack_reg    <= pack_with_bit;
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end else if (flush_exec) begin
        if (bit_cnt_reg != '0) begin
          act_out       <= pack_reg;
          act_count_out <= bit_cnt_reg;
          act_valid_out <= 1'b1;
        end
        pack_reg    <= '0;
        bit_cnt_reg <= '0;
      end
    end
  end

  assign busy_out = acc_busy | (bit_cnt_reg != '0) | (state_reg == ST_FLUSH_WAIT);

endmodule

// File: tb/tb_psum_binarizer.sv
// Directed and randomized bench for psum_binarizer with a queue-based reference
// model and an extra narrow-accumulator instance to exercise saturation.
module tb_psum_binarizer;

  localparam int WIDTH     = 14;
  localparam int ACC_WIDTH = 18;
  localparam int PASSES    = 4;
  localparam int SACC      = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        rst = 1'b1;
  logic                        flush = 1'b0;
  logic                        psum_valid = 1'b0;
  logic                        act_ready = 1'b1;
  logic signed [WIDTH-1:0]     psum = '0;
  logic signed [ACC_WIDTH-1:0] thr = '0;
  logic signed [SACC-1:0]      thr_s = '0;

  logic        ready, act_valid, busy;
  logic [26:0] act;
  logic [4:0]  cnt;
  logic        ready_s, act_valid_s, busy_s;
  logic [26:0] act_s;
  logic [4:0]  cnt_s;

  psum_binarizer #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .PASSES(PASSES)) dut (
    .clk_in(clk), .rst_in(rst), .cfg_threshold_in(thr),
    .psum_valid_in(psum_valid), .psum_ready_out(ready), .psum_in(psum),
    .flush_in(flush), .act_valid_out(act_valid), .act_ready_in(act_ready),
    .act_out(act), .act_count_out(cnt), .busy_out(busy)
  );

  psum_binarizer #(.WIDTH(WIDTH), .ACC_WIDTH(SACC), .PASSES(PASSES)) dut_sat (
    .clk_in(clk), .rst_in(rst), .cfg_threshold_in(thr_s),
    .psum_valid_in(psum_valid), .psum_ready_out(ready_s), .psum_in(psum),
    .flush_in(flush), .act_valid_out(act_valid_s), .act_ready_in(act_ready),
    .act_out(act_s), .act_count_out(cnt_s), .busy_out(busy_s)
  );

  int total = 0;
  int bad = 0;
  bit rand_ready = 1'b0;

  // Reference model: psums of the neuron in progress, finished bits, expected words.
  int          nps[$];
  bit          bits[$];
  logic [26:0] exp_word[$];
  int          exp_cnt[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic longint sat_sum(input int q[$], input int w);
    longint s = 0;
    longint hi = (64'sd1 <<< (w - 1)) - 1;
    longint lo = -(64'sd1 <<< (w - 1));
    foreach (q[i]) begin
      s = s + q[i];
      if (s > hi) s = hi;
      if (s < lo) s = lo;
    end
    return s;
  endfunction

  task automatic model_emit();
    logic [26:0] w = '0;
    for (int i = 0; i < bits.size(); i++) w[26 - i] = bits[i];
    exp_word.push_back(w);
    exp_cnt.push_back(bits.size());
    bits.delete();
  endtask

  task automatic model_psum(input int p, input longint t);
    nps.push_back(p);
    if (nps.size() == PASSES) begin
      bits.push_back(sat_sum(nps, ACC_WIDTH) >= t);
      nps.delete();
      if (bits.size() == 27) model_emit();
    end
  endtask

  task automatic model_flush();
    nps.delete();
    if (bits.size() > 0) model_emit();
  endtask

  task automatic model_reset();
    nps.delete();
    bits.delete();
    exp_word.delete();
    exp_cnt.delete();
  endtask

  // Observe this cycle's handshakes, then advance one clock.
  task automatic step();
    logic [26:0] w;
    int c;
    if (rst) begin
      model_reset();
    end else begin
      if (act_valid && act_ready) begin
        if (exp_word.size() == 0) begin
          chk("unexpected_word", act, 27'h0);
        end else begin
          w = exp_word.pop_front();
          c = exp_cnt.pop_front();
          chk("word_bits", act, w);
          chk("word_count", cnt, c);
          $display("word out: act=%07h count=%0d", act, cnt);
        end
      end
      if (psum_valid && ready) model_psum(int'(psum), longint'(thr));
      if (flush) model_flush();
    end
    @(posedge clk);
    #1;
    if (rand_ready) act_ready = ($urandom_range(0, 2) != 0);
    #1;
  endtask

  task automatic send_psum(input int p, input bit fl = 1'b0);
    int n = 0;
    psum = WIDTH'(p);
    psum_valid = 1'b1;
    #1;
    while (!ready && n < 200) begin
      step();
      n++;
    end
    chk("psum_ready_wait", ready, 1'b1);
    flush = fl;
    step();
    psum_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic send_neuron(input int p0, input int p1, input int p2, input int p3);
    send_psum(p0);
    send_psum(p1);
    send_psum(p2);
    send_psum(p3);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!act_valid && n < 50) begin
      step();
      n++;
    end
    chk(tag, act_valid, 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || act_valid || exp_word.size() != 0) && n < 200) begin
      step();
      n++;
    end
    chk("idle_wait", busy, 1'b0);
  endtask

  initial begin
    logic [26:0] held;
    int tmp;

    // Reset state
    step();
    step();
    chk("rst_valid", act_valid, 1'b0);
    chk("rst_act", act, 27'h0);
    chk("rst_count", cnt, 5'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready_low", ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", ready, 1'b1);

    // 108 psums of +1, threshold 0 -> all-ones word one cycle after last handshake
    thr = '0;
    for (int i = 0; i < 108; i++) send_psum(1);
    chk("full_latency_valid", act_valid, 1'b1);
    chk("full_word", act, 27'h7FFFFFF);
    chk("full_count", cnt, 5'd27);
    wait_idle();

    // Threshold boundary: sum 5 vs 5 -> 1 (bit 26), vs 6 -> 0
    thr = 18'sd5;
    send_neuron(2, 1, 1, 1);
    thr = 18'sd6;
    send_neuron(2, 1, 1, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_valid("boundary_valid");
    chk("boundary_word", act, 27'h4000000);
    chk("boundary_count", cnt, 5'd2);
    wait_idle();

    // Sign extension: four -1 psums, thresholds -4 and -3
    thr = -18'sd4;
    send_neuron(-1, -1, -1, -1);
    thr = -18'sd3;
    send_neuron(-1, -1, -1, -1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_valid("signext_valid");
    chk("signext_word", act, 27'h4000000);
    chk("signext_count", cnt, 5'd2);
    wait_idle();

    // Flush of a 5-bit partial word, then an empty flush
    thr = '0;
    for (int i = 0; i < 5; i++) send_neuron(1, 0, 0, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_valid("flush5_valid");
    chk("flush5_word", act, 27'h7C00000);
    chk("flush5_count", cnt, 5'd5);
    wait_idle();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("empty_flush_valid", act_valid, 1'b0);
    chk("empty_flush_busy", busy, 1'b0);

    // Flush asserted together with the last psum of a neuron
    send_psum(1);
    send_psum(1);
    send_psum(1);
    send_psum(1, 1'b1);
    wait_valid("flush_psum_valid");
    chk("flush_psum_word", act, 27'h4000000);
    chk("flush_psum_count", cnt, 5'd1);
    wait_idle();

    // Backpressure: hold the completed word, psums must stall without loss
    for (int i = 0; i < 26; i++) send_neuron(3, -1, 0, 0);
    act_ready = 1'b0;
    send_neuron(-5, 0, 0, 0);
    held = act;
    chk("bp_valid", act_valid, 1'b1);
    psum = 14'sd7;
    psum_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_ready_low", ready, 1'b0);
      chk("bp_act_stable", act, held);
    end
    act_ready = 1'b1;
    #1;
    chk("bp_release_ready", ready, 1'b1);
    step();
    psum_valid = 1'b0;
    send_psum(0);
    send_psum(0);
    send_psum(0);

    // Randomized traffic with random backpressure and occasional flushes
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (nps.size() == 0) begin
        tmp = int'($urandom_range(0, 1200)) - 600;
        thr = ACC_WIDTH'(tmp);
      end
      send_psum(int'($urandom_range(0, 600)) - 300);
      if ($urandom_range(0, 3) == 0) step();
      if (nps.size() == 0 && $urandom_range(0, 15) == 0) begin
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_idle();
      end
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_idle();
    rand_ready = 1'b0;
    act_ready = 1'b1;
    #1;

    // Reset mid-word: 10 bits pending are discarded, then a clean word
    thr = '0;
    for (int i = 0; i < 10; i++) send_neuron(1, 1, 1, 1);
    chk("midword_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_ready_low", ready, 1'b0);
    step();
    chk("midrst_valid", act_valid, 1'b0);
    chk("midrst_act", act, 27'h0);
    chk("midrst_count", cnt, 5'd0);
    chk("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 27; i++) begin
      tmp = int'($urandom_range(0, 40)) - 20;
      thr = ACC_WIDTH'(tmp);
      send_neuron(int'($urandom_range(0, 20)) - 10, int'($urandom_range(0, 20)) - 10,
                  int'($urandom_range(0, 20)) - 10, int'($urandom_range(0, 20)) - 10);
    end
    chk("clean_word_valid", act_valid, 1'b1);
    chk("clean_word_count", cnt, 5'd27);
    wait_idle();

    // Saturation in the 15-bit accumulator instance
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("sat_ready", ready_s, 1'b1);
    thr = 18'sd16383;
    thr_s = 15'sd16383;
    send_neuron(8191, 8191, 8191, 8191);
    thr = -18'sd16383;
    thr_s = -15'sd16383;
    send_neuron(-8192, -8192, -8192, -8192);
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_valid("sat_valid");
    chk("sat_valid_narrow", act_valid_s, 1'b1);
    chk("sat_word", act_s, 27'h4000000);
    chk("sat_count", cnt_s, 5'd2);
    wait_idle();
    chk("sat_busy_narrow", busy_s, 1'b0);

    chk("leftover_words", 64'(exp_word.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
